// File: rtl/ecc32_pkg.sv
// Shared Hsiao 39/32 SEC-DED constants: codeword geometry, check-row masks
// and the occupancy states of the encoder pipeline.
package ecc32_pkg;

    localparam int DATA_W  = 32;
    localparam int CHECK_W = 7;
    localparam int CODE_W  = 39;

    localparam logic [31:0] ROW_MASK_0 = 32'h2C02_21FF;
    localparam logic [31:0] ROW_MASK_1 = 32'h13E5_101F;
    localparam logic [31:0] ROW_MASK_2 = 32'hC06C_89E1;
    localparam logic [31:0] ROW_MASK_3 = 32'h7D9C_4422;
    localparam logic [31:0] ROW_MASK_4 = 32'hA2BB_C244;
    localparam logic [31:0] ROW_MASK_5 = 32'h8B50_3E88;
    localparam logic [31:0] ROW_MASK_6 = 32'h5403_FF10;

    // Element k of this packed array is the mask of check row k.
    localparam logic [CHECK_W-1:0][DATA_W-1:0] ROW_MASK = {
        ROW_MASK_6, ROW_MASK_5, ROW_MASK_4, ROW_MASK_3,
        ROW_MASK_2, ROW_MASK_1, ROW_MASK_0
    };

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/hsiao32_parity.sv
// Combinational Hsiao 39/32 check-bit generator: check[k] is the parity of
// the data bits selected by row mask k.
module hsiao32_parity
    import ecc32_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    output logic [CHECK_W-1:0] check
);

    for (genvar k = 0; k < CHECK_W; k++) begin : g_row
        assign check[k] = ^(data & ROW_MASK[k]);
    end

endmodule

// File: rtl/enc_32_pipe.sv
// Registered Hsiao 39/32 encoder with a two-entry skid buffer and a saturating
// output counter. Define ENC32_ERRINJ_EN to add the INJ error-injection port.
module enc_32_pipe
    import ecc32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    input  logic [DATA_W-1:0] IN,
`ifdef ENC32_ERRINJ_EN
    input  logic [CODE_W-1:0] INJ,
`endif
    output logic              OUT_VLD,
    input  logic              OUT_RDY,
    output logic [CODE_W-1:0] OUT,
    output logic [CNT_W-1:0]  CNT
);

    occ_state_t          state;
    logic [CODE_W-1:0]   main_q;
    logic [CODE_W-1:0]   skid_q;
    logic [CHECK_W-1:0]  check;
    logic [CODE_W-1:0]   new_code;
    logic                in_xfer;
    logic                out_xfer;

    hsiao32_parity u_parity (
        .data  (IN),
        .check (check)
    );

`ifdef ENC32_ERRINJ_EN
    assign new_code = {check, IN} ^ INJ;
`else
    assign new_code = {check, IN};
`endif

    assign in_xfer  = IN_VLD & IN_RDY;
    assign out_xfer = OUT_VLD & OUT_RDY;
    assign OUT      = main_q;

    // IN_RDY and OUT_VLD are registered alongside the state so the upstream
    // ready never depends combinationally on OUT_RDY.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= EMPTY;
            OUT_VLD <= 1'b0;
            IN_RDY  <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
            CNT     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= new_code;
                        OUT_VLD <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            skid_q <= new_code;
                            IN_RDY <= 1'b0;
                            state  <= FULL;
                        end
                        2'b01: begin
                            OUT_VLD <= 1'b0;
                            state   <= EMPTY;
                        end
                        2'b11: main_q <= new_code;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        IN_RDY <= 1'b1;
                        state  <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    OUT_VLD <= 1'b0;
                    IN_RDY  <= 1'b1;
                end
            endcase

            if (out_xfer && (CNT != {CNT_W{1'b1}})) begin
                CNT <= CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_enc_32_pipe.sv
// Directed self-checking bench for enc_32_pipe; the INJ checks are compiled
// only when ENC32_ERRINJ_EN is defined.
module tb_enc_32_pipe;

    localparam int CNT_W = 3;
    localparam int N_STREAM = 40;

    logic              CLK;
    logic              RST;
    logic              IN_VLD;
    logic              IN_RDY;
    logic [31:0]       IN;
    logic              OUT_VLD;
    logic              OUT_RDY;
    logic [38:0]       OUT;
    logic [CNT_W-1:0]  CNT;
`ifdef ENC32_ERRINJ_EN
    logic [38:0]       inj;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    enc_32_pipe #(.CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .IN_VLD  (IN_VLD),
        .IN_RDY  (IN_RDY),
        .IN      (IN),
`ifdef ENC32_ERRINJ_EN
        .INJ     (inj),
`endif
        .OUT_VLD (OUT_VLD),
        .OUT_RDY (OUT_RDY),
        .OUT     (OUT),
        .CNT     (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference check bits written straight from the row bit lists.
    function automatic logic [6:0] ref_check(input logic [31:0] d);
        logic [6:0] k;
        k[0] = ^{d[8:0], d[13], d[17], d[26], d[27], d[29]};
        k[1] = ^{d[4:0], d[12], d[16], d[18], d[25:21], d[28]};
        k[2] = ^{d[0], d[8:5], d[11], d[15], d[19:18], d[22:21], d[31:30]};
        k[3] = ^{d[1], d[5], d[10], d[14], d[20:18], d[24:23], d[30:26]};
        k[4] = ^{d[2], d[6], d[9], d[17:14], d[21:19], d[23], d[25], d[29], d[31]};
        k[5] = ^{d[3], d[7], d[13:9], d[20], d[22], d[25:24], d[27], d[31]};
        k[6] = ^{d[4], d[17:8], d[26], d[28], d[30]};
        return k;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data);
        IN     = data;
        IN_VLD = 1'b1;
        tick();
        IN_VLD = 1'b0;
    endtask

    logic [31:0] words [N_STREAM];

    initial begin
        RST     = 1'b1;
        IN_VLD  = 1'b0;
        IN      = '0;
        OUT_RDY = 1'b1;
`ifdef ENC32_ERRINJ_EN
        inj     = '0;
`endif
        tick();
        tick();
        checkOutput("rst_out_vld", 64'(OUT_VLD), 64'd0);
        checkOutput("rst_in_rdy",  64'(IN_RDY),  64'd1);
        checkOutput("rst_out",     64'(OUT),     64'd0);
        checkOutput("rst_cnt",     64'(CNT),     64'd0);
        RST = 1'b0;
        tick();
        checkOutput("rdy_after_rst", 64'(IN_RDY), 64'd1);

        // Directed vectors; k2 and k5 rows have odd weight, hence 0x24 for all-ones.
        applyStimulus(32'h0000_0000);
        checkOutput("vld_zero", 64'(OUT_VLD), 64'd1);
        checkOutput("enc_zero", 64'(OUT), 64'(39'h00_0000_0000));
        applyStimulus(32'h0000_0001);
        checkOutput("enc_one", 64'(OUT), 64'(39'h07_0000_0001));
        applyStimulus(32'hFFFF_FFFF);
        checkOutput("enc_ones", 64'(OUT), 64'(39'h24_FFFF_FFFF));
        applyStimulus(32'h8000_0000);
        checkOutput("enc_bit31", 64'(OUT), 64'(39'h34_8000_0000));
        applyStimulus(32'h0000_0100);
        checkOutput("enc_bit8", 64'(OUT), 64'(39'h45_0000_0100));
        tick();
        checkOutput("drain_vld", 64'(OUT_VLD), 64'd0);
        checkOutput("cnt_five",  64'(CNT),     64'd5);

        // Backpressure: A, B fill both entries, C is held off.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        OUT_RDY = 1'b0;
        IN_VLD  = 1'b1;
        IN      = 32'h0000_0001;
        tick();
        checkOutput("bp_rdy_a", 64'(IN_RDY), 64'd1);
        IN = 32'h0000_0100;
        tick();
        checkOutput("bp_rdy_b", 64'(IN_RDY), 64'd0);
        IN = 32'h0001_0000;
        tick();
        checkOutput("bp_rdy_c", 64'(IN_RDY), 64'd0);
        checkOutput("bp_hold_a", 64'(OUT), 64'(39'h07_0000_0001));
        tick();
        checkOutput("bp_stable_vld", 64'(OUT_VLD), 64'd1);
        checkOutput("bp_stable_a", 64'(OUT), 64'(39'h07_0000_0001));
        OUT_RDY = 1'b1;
        tick();
        checkOutput("bp_out_b", 64'(OUT), 64'(39'h45_0000_0100));
        checkOutput("bp_rdy_reopen", 64'(IN_RDY), 64'd1);
        tick();
        IN_VLD = 1'b0;
        checkOutput("bp_out_c", 64'(OUT), 64'(39'h52_0001_0000));
        checkOutput("bp_vld_c", 64'(OUT_VLD), 64'd1);
        tick();
        checkOutput("bp_empty", 64'(OUT_VLD), 64'd0);
        checkOutput("bp_cnt",   64'(CNT),     64'd3);

        // Reset while FULL discards both entries and the word presented with it.
        OUT_RDY = 1'b0;
        IN_VLD  = 1'b1;
        IN      = 32'h0000_1234;
        tick();
        IN = 32'h0000_5678;
        tick();
        checkOutput("full_rdy", 64'(IN_RDY), 64'd0);
        RST = 1'b1;
        tick();
        RST     = 1'b0;
        IN_VLD  = 1'b0;
        OUT_RDY = 1'b1;
        checkOutput("rstfull_vld", 64'(OUT_VLD), 64'd0);
        checkOutput("rstfull_cnt", 64'(CNT),     64'd0);
        checkOutput("rstfull_rdy", 64'(IN_RDY),  64'd1);
        tick();
        checkOutput("rstfull_no_ghost", 64'(OUT_VLD), 64'd0);

        // Streaming at one word per cycle; the narrow counter saturates.
        for (int i = 0; i < N_STREAM; i++) words[i] = $urandom;
        IN_VLD = 1'b1;
        IN     = words[0];
        tick();
        for (int i = 1; i < N_STREAM; i++) begin
            checkOutput("stream_vld", 64'(OUT_VLD), 64'd1);
            checkOutput("stream_rdy", 64'(IN_RDY),  64'd1);
            checkOutput("stream_out", 64'(OUT), 64'({ref_check(words[i-1]), words[i-1]}));
            IN = words[i];
            tick();
        end
        IN_VLD = 1'b0;
        checkOutput("stream_last", 64'(OUT),
                    64'({ref_check(words[N_STREAM-1]), words[N_STREAM-1]}));
        tick();
        checkOutput("stream_done", 64'(OUT_VLD), 64'd0);
        checkOutput("cnt_saturate", 64'(CNT), 64'd7);

`ifdef ENC32_ERRINJ_EN
        inj = 39'd1 << 5;
        applyStimulus(32'h0000_0001);
        inj = '0;
        checkOutput("inj_single", 64'(OUT), 64'(39'h07_0000_0021));
        inj = 39'd3;
        applyStimulus(32'h0000_0000);
        inj = '0;
        checkOutput("inj_double", 64'(OUT), 64'(39'h00_0000_0003));
        applyStimulus(32'h0000_0001);
        checkOutput("inj_cleared", 64'(OUT), 64'(39'h07_0000_0001));
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
